// File: rtl/regfile_pkg.sv
// regfile_pkg: widths, constants and types shared by the register file, the MEM/WB pipeline
// register and the ID stage.
//   REG_ADDR_WIDTH / REG_DATA_WIDTH : register index and data widths.
//   ZERO_WORD                       : all-zero data word.
//   REG_{WRITE,READ}_{ENABLE,DISABLE}: enable encodings on the WB and ID interfaces.
// The `REG_ADDR_WIDTH, `REG_DATA_WIDTH and `ZERO_WORD macros are also provided for
// macro-based consumers; the package localparams derive from them so they cannot diverge.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif

package regfile_pkg;

    localparam int unsigned REG_ADDR_WIDTH = `REG_ADDR_WIDTH;
    localparam int unsigned REG_DATA_WIDTH = `REG_DATA_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    localparam reg_data_t ZERO_WORD = `ZERO_WORD;

    localparam logic REG_WRITE_ENABLE  = 1'b1;
    localparam logic REG_WRITE_DISABLE = 1'b0;
    localparam logic REG_READ_ENABLE   = 1'b1;
    localparam logic REG_READ_DISABLE  = 1'b0;

    // Index -> address conversion so callers avoid width warnings on compares.
    function automatic reg_addr_t to_reg_addr(input int unsigned idx);
        return reg_addr_t'(idx);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port of the register file.
// Resolves, highest priority first: reset -> 0, disabled -> 0, zero register -> 0,
// WB bypass hit (only with REGFILE_WB_BYPASS_EN defined) -> write data, otherwise the
// stored value supplied by the parent.
// Ports:
//   rst_n      : active-low reset, forces the output to zero.
//   r_en       : port enable.
//   r_addr     : register index being read.
//   r_store    : storage contents at r_addr (selected by the parent).
//   w_reg_en   : WB write enable (used by the bypass compare).
//   w_reg_addr : WB write destination.
//   w_reg_data : WB write data.
//   r_data     : resolved read data.
// Macro: REGFILE_WB_BYPASS_EN enables same-cycle WB->ID forwarding.

module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                      rst_n,
    input  logic                      r_en,
    input  logic [REG_ADDR_WIDTH-1:0] r_addr,
    input  logic [REG_DATA_WIDTH-1:0] r_store,
    input  logic                      w_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0] w_reg_data,
    output logic [REG_DATA_WIDTH-1:0] r_data
);

    localparam reg_addr_t ZeroAddr = reg_addr_t'(ZERO_REG);

`ifdef REGFILE_WB_BYPASS_EN
    logic bypass_hit;
    // Zero-register case is already excluded by the higher-priority branch below.
    assign bypass_hit = (w_reg_en == REG_WRITE_ENABLE) && (w_reg_addr == r_addr);
`else
    // Without the bypass the write interface does not influence the read.
    logic unused_wb;
    assign unused_wb = ^{w_reg_en, w_reg_addr, w_reg_data};
`endif

    always_comb begin
        r_data = ZERO_WORD;
        if (!rst_n) begin
            r_data = ZERO_WORD;
        end else if (r_en != REG_READ_ENABLE) begin
            r_data = ZERO_WORD;
        end else if (r_addr == ZeroAddr) begin
            r_data = ZERO_WORD;
`ifdef REGFILE_WB_BYPASS_EN
        end else if (bypass_hit) begin
            r_data = w_reg_data;
`endif
        end else begin
            r_data = r_store;
        end
    end

endmodule

// File: rtl/regfile.sv
// regfile: general-purpose register file of the 5-stage MIPS core.
// One synchronous write port fed by MEM/WB, two combinational read ports serving ID.
// Register ZERO_REG reads as zero and silently ignores writes.
// Ports:
//   clk        : core clock, rising edge.
//   rst_n      : asynchronous active-low reset; clears every register immediately.
//   w_reg_en   : write enable from MEM/WB.
//   w_reg_addr : write destination.
//   w_reg_data : write data.
//   r1_en / r1_addr / r1_data : read port 1 (rs).
//   r2_en / r2_addr / r2_data : read port 2 (rt).
// Macro: REGFILE_WB_BYPASS_EN -- when defined, a read of the register being written in the
// same cycle returns the new data; when undefined it returns the old stored value.
// REG_NUM must equal 2**REG_ADDR_WIDTH so every address decodes to a real entry.

module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned REG_NUM  = 32,
    parameter int unsigned ZERO_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      w_reg_en,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr,
    input  logic [REG_DATA_WIDTH-1:0] w_reg_data,
    input  logic                      r1_en,
    input  logic [REG_ADDR_WIDTH-1:0] r1_addr,
    output logic [REG_DATA_WIDTH-1:0] r1_data,
    input  logic                      r2_en,
    input  logic [REG_ADDR_WIDTH-1:0] r2_addr,
    output logic [REG_DATA_WIDTH-1:0] r2_data
);

    localparam reg_addr_t ZeroAddr = reg_addr_t'(ZERO_REG);

    reg_data_t storage_q [REG_NUM];
    reg_data_t storage_d [REG_NUM];

    always_comb begin
        storage_d = storage_q;
        if ((w_reg_en == REG_WRITE_ENABLE) && (w_reg_addr != ZeroAddr)) begin
            storage_d[w_reg_addr] = w_reg_data;
        end
    end

    // A write on the same edge as reset assertion is lost: reset wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            storage_q <= '{default: ZERO_WORD};
        end else begin
            storage_q <= storage_d;
        end
    end

    regfile_rd_port #(
        .ZERO_REG (ZERO_REG)
    ) u_rd_port1 (
        .rst_n      (rst_n),
        .r_en       (r1_en),
        .r_addr     (r1_addr),
        .r_store    (storage_q[r1_addr]),
        .w_reg_en   (w_reg_en),
        .w_reg_addr (w_reg_addr),
        .w_reg_data (w_reg_data),
        .r_data     (r1_data)
    );

    regfile_rd_port #(
        .ZERO_REG (ZERO_REG)
    ) u_rd_port2 (
        .rst_n      (rst_n),
        .r_en       (r2_en),
        .r_addr     (r2_addr),
        .r_store    (storage_q[r2_addr]),
        .w_reg_en   (w_reg_en),
        .w_reg_addr (w_reg_addr),
        .w_reg_data (w_reg_data),
        .r_data     (r2_data)
    );

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed testbench for regfile with a behavioural reference model.
// Inputs change 1 time unit after each rising edge; outputs are compared on every falling
// edge against the model, plus literal checks at key points of the directed sequence.

module tb_regfile;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        w_reg_en;
    logic [4:0]  w_reg_addr;
    logic [31:0] w_reg_data;
    logic        r1_en;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic        r2_en;
    logic [4:0]  r2_addr;
    logic [31:0] r2_data;

    int tests_run;
    int tests_failed;

    logic [31:0] model_mem [32];

    regfile #(
        .REG_NUM  (32),
        .ZERO_REG (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .w_reg_en   (w_reg_en),
        .w_reg_addr (w_reg_addr),
        .w_reg_data (w_reg_data),
        .r1_en      (r1_en),
        .r1_addr    (r1_addr),
        .r1_data    (r1_data),
        .r2_en      (r2_en),
        .r2_addr    (r2_addr),
        .r2_data    (r2_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference storage: cleared asynchronously, written on the edge unless the target is r0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model_mem[i] <= 32'h0;
        end else if (w_reg_en && w_reg_addr != 5'd0) begin
            model_mem[w_reg_addr] <= w_reg_data;
        end
    end

    function automatic logic [31:0] exp_read(input logic en, input logic [4:0] addr);
        if (!rst_n) return 32'h0;
        if (!en) return 32'h0;
        if (addr == 5'd0) return 32'h0;
`ifdef REGFILE_WB_BYPASS_EN
        if (w_reg_en && w_reg_addr == addr) return w_reg_data;
`endif
        return model_mem[addr];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_r1", r1_data, exp_read(r1_en, r1_addr));
        check("model_r2", r2_data, exp_read(r2_en, r2_addr));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic en, input logic [4:0] a, input logic [31:0] d);
        w_reg_en   = en;
        w_reg_addr = a;
        w_reg_data = d;
    endtask

    task automatic set_read(input logic e1, input logic [4:0] a1,
                            input logic e2, input logic [4:0] a2);
        r1_en   = e1;
        r1_addr = a1;
        r2_en   = e2;
        r2_addr = a2;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        set_write(1'b0, 5'd0, 32'h0);
        set_read(1'b1, 5'd1, 1'b1, 5'd2);

        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_r1", r1_data, 32'h0);
        check("reset_r2", r2_data, 32'h0);

        // Reset: write r5, then assert reset mid-cycle while another write is pending.
        next_cycle();
        rst_n = 1'b1;
        set_write(1'b1, 5'd5, 32'hDEAD_BEEF);
        set_read(1'b1, 5'd5, 1'b1, 5'd0);
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("r5_written", r1_data, 32'hDEAD_BEEF);
        #1;
        set_write(1'b1, 5'd5, 32'h5555_5555);
        rst_n = 1'b0;
        #1;
        check("reset_immediate", r1_data, 32'h0);
        next_cycle();
        rst_n = 1'b1;
        set_write(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("r5_after_reset", r1_data, 32'h0);

        // Write / readback on both ports, then disable port 1.
        next_cycle();
        set_write(1'b1, 5'd7, 32'h1234_5678);
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        set_read(1'b1, 5'd7, 1'b1, 5'd7);
        @(negedge clk);
        check("r7_port1", r1_data, 32'h1234_5678);
        check("r7_port2", r2_data, 32'h1234_5678);
        next_cycle();
        set_read(1'b0, 5'd7, 1'b1, 5'd7);
        @(negedge clk);
        check("r7_port1_disabled", r1_data, 32'h0);
        check("r7_port2_enabled", r2_data, 32'h1234_5678);

        // Zero register: write is dropped, reads stay zero, also during the write cycle.
        next_cycle();
        set_write(1'b1, 5'd0, 32'hFFFF_FFFF);
        set_read(1'b1, 5'd0, 1'b1, 5'd0);
        @(negedge clk);
        check("r0_during_write", r1_data, 32'h0);
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("r0_port1", r1_data, 32'h0);
            check("r0_port2", r2_data, 32'h0);
            next_cycle();
        end

        // Same-cycle collision on r9.
        set_write(1'b1, 5'd9, 32'h11);
        next_cycle();
        set_write(1'b1, 5'd9, 32'h22);
        set_read(1'b1, 5'd9, 1'b0, 5'd9);
        @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
        check("collision_same_cycle", r1_data, 32'h22);
`else
        check("collision_same_cycle", r1_data, 32'h11);
`endif
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        check("collision_next_cycle", r1_data, 32'h22);

        // Dual-port independence with a mid-cycle address swap.
        next_cycle();
        set_write(1'b1, 5'd3, 32'hA);
        next_cycle();
        set_write(1'b1, 5'd4, 32'hB);
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        set_read(1'b1, 5'd3, 1'b1, 5'd4);
        @(negedge clk);
        check("dual_r1_r3", r1_data, 32'hA);
        check("dual_r2_r4", r2_data, 32'hB);
        #1;
        set_read(1'b1, 5'd4, 1'b1, 5'd3);
        #1;
        check("swap_r1_r4", r1_data, 32'hB);
        check("swap_r2_r3", r2_data, 32'hA);

        // Full sweep: write r1..r31 back-to-back, then read every register on both ports.
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            set_write(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
        end
        next_cycle();
        set_write(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            set_read(1'b1, 5'(i), 1'b1, 5'(31 - i));
            @(negedge clk);
            check("sweep_r1", r1_data, 32'(i) * 32'h0101_0101);
            check("sweep_r2", r2_data, 32'(31 - i) * 32'h0101_0101);
            next_cycle();
        end
        // Pin the model on a few hand-computed sweep values.
        check("model_r31", model_mem[31], 32'h1F1F_1F1F);
        check("model_r16", model_mem[16], 32'h1010_1010);
        check("model_r0", model_mem[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
